// File: rtl/if_stage_if.sv
// if_stage_if - bus bundle between the fetch stage and its environment.
//   Carries the instruction-memory address/data pair and the decode-facing
//   outputs (captured instruction, its PC, valid flag, fetch counter).
//   master : the fetch stage (drives address and decode outputs)
//   slave  : memory/decode side (drives instruction read data)
interface if_stage_if #(
    parameter int unsigned PC_W = 32
);
    logic [PC_W-1:0] imem_addr_o;
    logic [31:0]     imem_data_i;
    logic [31:0]     inst_o;
    logic [PC_W-1:0] inst_pc_o;
    logic            inst_valid_o;
    logic [31:0]     fetch_cnt_o;

    modport master (
        output imem_addr_o,
        input  imem_data_i,
        output inst_o,
        output inst_pc_o,
        output inst_valid_o,
        output fetch_cnt_o
    );

    modport slave (
        input  imem_addr_o,
        output imem_data_i,
        input  inst_o,
        input  inst_pc_o,
        input  inst_valid_o,
        input  fetch_cnt_o
    );
endinterface

// File: rtl/if_stage.sv
// if_stage - instruction-fetch stage owning the PC.
//   Advances either on a free-running divider tick (run_i=1) or on a
//   debounced-by-synchronizer push-button edge (run_i=0). Supports stall with
//   a one-deep pending event, PC redirect with instruction flush, and a
//   completed-fetch counter.
// Ports:
//   clk, rst       : system clock, asynchronous active-high reset
//   run_i          : 1 = free-run on divider tick, 0 = single-step
//   step_i         : raw step button (asynchronous)
//   stall_i        : hold fetch
//   redirect_i     : load redirect_pc_i, invalidate instruction register
//   redirect_pc_i  : redirect target
//   bus            : imem address/data and decode outputs (master side)
module if_stage #(
    parameter int unsigned         PC_W     = 32,
    parameter logic [PC_W-1:0]     RESET_PC = '0,
    parameter logic [PC_W-1:0]     PC_INC   = PC_W'(1),
    parameter int unsigned         DIV_W    = 28
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run_i,
    input  logic            step_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    if_stage_if.master      bus
);

    logic [DIV_W-1:0] r_div;
    logic             r_step_s1;
    logic             r_step_s2;
    logic             r_step_d;
    logic             r_pend;
    logic [PC_W-1:0]  r_pc;
    logic [31:0]      r_inst;
    logic [PC_W-1:0]  r_inst_pc;
    logic             r_inst_valid;
    logic [31:0]      r_fetch_cnt;

    logic             w_tick;
    logic             w_step_rise;
    logic             w_event;
    logic             w_adv;

    assign w_tick      = &r_div;
    // r_step_d is the previous synchronized level; a held button gives one pulse
    assign w_step_rise = r_step_s2 & ~r_step_d;
    assign w_event     = run_i ? w_tick : w_step_rise;
    assign w_adv       = (w_event | r_pend) & ~stall_i & ~redirect_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div        <= '0;
            r_step_s1    <= 1'b0;
            r_step_s2    <= 1'b0;
            r_step_d     <= 1'b0;
            r_pend       <= 1'b0;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_fetch_cnt  <= '0;
        end else begin
            r_div     <= r_div + DIV_W'(1);
            r_step_s1 <= step_i;
            r_step_s2 <= r_step_s1;
            r_step_d  <= r_step_s2;

            if (redirect_i) begin
                // coincident events are dropped along with any pending one
                r_pc         <= redirect_pc_i;
                r_inst_valid <= 1'b0;
                r_pend       <= 1'b0;
            end else if (w_adv) begin
                r_inst       <= bus.imem_data_i;
                r_inst_pc    <= r_pc;
                r_inst_valid <= 1'b1;
                r_pc         <= r_pc + PC_INC;
                r_fetch_cnt  <= r_fetch_cnt + 32'd1;
                r_pend       <= 1'b0;
            end else if (w_event) begin
                // only reachable while stalled; extra events merge into one
                r_pend <= 1'b1;
            end
        end
    end

    assign bus.imem_addr_o  = r_pc;
    assign bus.inst_o       = r_inst;
    assign bus.inst_pc_o    = r_inst_pc;
    assign bus.inst_valid_o = r_inst_valid;
    assign bus.fetch_cnt_o  = r_fetch_cnt;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    localparam int DIVW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc = '0;
    logic [31:0] data = '0;
    logic [3:0]  rpc_w;

    always #5 clk = ~clk;

    if_stage_if #(.PC_W(32)) bus ();
    if_stage_if #(.PC_W(4))  bus_w ();

    assign bus.imem_data_i   = data;
    assign bus_w.imem_data_i = data;
    assign rpc_w             = rpc[3:0];

    if_stage #(.PC_W(32), .RESET_PC(32'd0), .PC_INC(32'd1), .DIV_W(DIVW)) dut (
        .clk(clk), .rst(rst), .run_i(run), .step_i(step), .stall_i(stall),
        .redirect_i(redir), .redirect_pc_i(rpc), .bus(bus)
    );

    if_stage #(.PC_W(4), .RESET_PC(4'd0), .PC_INC(4'd1), .DIV_W(DIVW)) dut_w (
        .clk(clk), .rst(rst), .run_i(run), .step_i(step), .stall_i(stall),
        .redirect_i(redir), .redirect_pc_i(rpc_w), .bus(bus_w)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: works from "edges since reset" and a history of the
    // step level seen at each edge.
    logic [31:0] m_pc, m_inst, m_ipc, m_cnt;
    logic        m_valid;
    bit          m_pend;
    int          m_n;
    bit          samp[$];

    task automatic model_reset();
        m_pc = 0; m_inst = 0; m_ipc = 0; m_cnt = 0; m_valid = 0;
        m_pend = 0; m_n = 0; samp.delete();
    endtask

    task automatic model_edge();
        bit tick, rise, ev;
        int sz;
        m_n++;
        samp.push_back(step);
        if (samp.size() > 8) void'(samp.pop_front());
        sz = samp.size();
        // button level seen at edge k-2 high, at edge k-3 low
        rise = (sz >= 3) && samp[sz-3] && ((sz < 4) || !samp[sz-4]);
        tick = (m_n % (1 << DIVW)) == 0;
        ev = run ? tick : rise;
        if (redir) begin
            m_pc = rpc; m_valid = 0; m_pend = 0;
        end else if ((ev || m_pend) && !stall) begin
            m_inst = data; m_ipc = m_pc; m_valid = 1;
            m_pc = m_pc + 1; m_cnt = m_cnt + 1; m_pend = 0;
        end else if (ev) begin
            m_pend = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        step = 0; stall = 0; redir = 0; rpc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        idle();
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic press();
        step = 1;
        repeat (3) cycle();
        step = 0;
        cycle();
    endtask

    task automatic check_model(input string tag);
        chk({tag, " pc"},       bus.imem_addr_o,     m_pc);
        chk({tag, " inst"},     bus.inst_o,          m_inst);
        chk({tag, " inst_pc"},  bus.inst_pc_o,       m_ipc);
        chk({tag, " valid"},    bus.inst_valid_o,    m_valid);
        chk({tag, " cnt"},      bus.fetch_cnt_o,     m_cnt);
        chk({tag, " w_pc"},     bus_w.imem_addr_o,   m_pc[3:0]);
        chk({tag, " w_inst_pc"}, bus_w.inst_pc_o,    m_ipc[3:0]);
        chk({tag, " w_cnt"},    bus_w.fetch_cnt_o,   m_cnt);
    endtask

    typedef struct {
        logic        run, step, stall, redir;
        logic [31:0] rpc, data;
        logic [31:0] e_pc, e_inst, e_ipc;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [31:0] c0;

        tbl[0]  = '{0,0,0,0, 32'h0,  32'h0,        32'h0,  32'h0,        32'h0,  0, 32'd0};
        tbl[1]  = '{0,1,0,0, 32'h0,  32'h0,        32'h0,  32'h0,        32'h0,  0, 32'd0};
        tbl[2]  = '{0,1,0,0, 32'h0,  32'h0,        32'h0,  32'h0,        32'h0,  0, 32'd0};
        tbl[3]  = '{0,1,0,0, 32'h0,  32'h00500093, 32'h1,  32'h00500093, 32'h0,  1, 32'd1};
        tbl[4]  = '{0,1,0,0, 32'h0,  32'h0000dead, 32'h1,  32'h00500093, 32'h0,  1, 32'd1};
        tbl[5]  = '{0,0,0,0, 32'h0,  32'h0000dead, 32'h1,  32'h00500093, 32'h0,  1, 32'd1};
        tbl[6]  = '{0,0,1,1, 32'h40, 32'h0000dead, 32'h40, 32'h00500093, 32'h0,  0, 32'd1};
        tbl[7]  = '{0,1,0,0, 32'h0,  32'h11,       32'h40, 32'h00500093, 32'h0,  0, 32'd1};
        tbl[8]  = '{0,1,0,0, 32'h0,  32'h11,       32'h40, 32'h00500093, 32'h0,  0, 32'd1};
        tbl[9]  = '{0,1,1,0, 32'h0,  32'h11,       32'h40, 32'h00500093, 32'h0,  0, 32'd1};
        tbl[10] = '{0,0,0,0, 32'h0,  32'h22,       32'h41, 32'h22,       32'h40, 1, 32'd2};

        model_reset();
        repeat (2) @(negedge clk);
        chk("rst pc",    bus.imem_addr_o,  32'h0);
        chk("rst inst",  bus.inst_o,       32'h0);
        chk("rst ipc",   bus.inst_pc_o,    32'h0);
        chk("rst valid", bus.inst_valid_o, 1'b0);
        chk("rst cnt",   bus.fetch_cnt_o,  32'h0);
        rst = 0;

        // table: single step, redirect+stall flush, pending capture
        foreach (tbl[i]) begin
            run = tbl[i].run; step = tbl[i].step; stall = tbl[i].stall;
            redir = tbl[i].redir; rpc = tbl[i].rpc; data = tbl[i].data;
            cycle();
            chk($sformatf("tbl%0d pc", i),    bus.imem_addr_o,  tbl[i].e_pc);
            chk($sformatf("tbl%0d inst", i),  bus.inst_o,       tbl[i].e_inst);
            chk($sformatf("tbl%0d ipc", i),   bus.inst_pc_o,    tbl[i].e_ipc);
            chk($sformatf("tbl%0d valid", i), bus.inst_valid_o, tbl[i].e_valid);
            chk($sformatf("tbl%0d cnt", i),   bus.fetch_cnt_o,  tbl[i].e_cnt);
        end

        // held button: exactly one capture, 3 edges after the rise
        idle();
        data = 32'h00500093;
        step = 1;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (k == 2)  chk("hold early cnt", bus.fetch_cnt_o, 32'd2);
            if (k == 3)  chk("hold cap cnt",   bus.fetch_cnt_o, 32'd3);
            if (k == 20) chk("hold end cnt",   bus.fetch_cnt_o, 32'd3);
        end
        chk("hold pc", bus.imem_addr_o, 32'h42);
        step = 0;
        cycle();

        // stall with two presses: one merged pending capture
        stall = 1;
        press();
        press();
        chk("stall pc",  bus.imem_addr_o, 32'h42);
        chk("stall cnt", bus.fetch_cnt_o, 32'd3);
        stall = 0;
        cycle();
        chk("pend pc",  bus.imem_addr_o, 32'h43);
        chk("pend cnt", bus.fetch_cnt_o, 32'd4);
        repeat (3) cycle();
        chk("pend once cnt", bus.fetch_cnt_o, 32'd4);

        // async reset mid-run, then first tick capture at edge 16
        run = 1;
        repeat (10) cycle();
        #2 rst = 1;
        #1;
        chk("arst pc",    bus.imem_addr_o,  32'h0);
        chk("arst valid", bus.inst_valid_o, 1'b0);
        chk("arst cnt",   bus.fetch_cnt_o,  32'h0);
        chk("arst inst",  bus.inst_o,       32'h0);
        model_reset();
        idle();
        data = 32'habcd0001;
        @(negedge clk);
        rst = 0;
        repeat (15) cycle();
        chk("tick15 pc",  bus.imem_addr_o, 32'h0);
        chk("tick15 cnt", bus.fetch_cnt_o, 32'h0);
        cycle();
        chk("tick16 pc",   bus.imem_addr_o, 32'h1);
        chk("tick16 ipc",  bus.inst_pc_o,   32'h0);
        chk("tick16 inst", bus.inst_o,      32'habcd0001);
        chk("tick16 cnt",  bus.fetch_cnt_o, 32'd1);

        // redirect wins over coincident tick and stall
        redir = 1; rpc = 32'h5;
        cycle();
        idle();
        repeat (14) cycle();
        chk("pre redir pc", bus.imem_addr_o, 32'h5);
        redir = 1; rpc = 32'h40; stall = 1;
        cycle();
        chk("redir pc",    bus.imem_addr_o,  32'h40);
        chk("redir valid", bus.inst_valid_o, 1'b0);
        chk("redir cnt",   bus.fetch_cnt_o,  32'd1);
        idle();
        repeat (15) cycle();
        chk("post redir hold", bus.imem_addr_o, 32'h40);
        cycle();
        chk("post redir pc",  bus.imem_addr_o, 32'h41);
        chk("post redir ipc", bus.inst_pc_o,   32'h40);
        chk("post redir cnt", bus.fetch_cnt_o, 32'd2);

        // mode isolation
        run = 0;
        c0 = bus.fetch_cnt_o;
        repeat (40) cycle();
        chk("tick ignored cnt", bus.fetch_cnt_o, m_cnt);
        chk("tick ignored delta", bus.fetch_cnt_o - c0, 32'd0);
        run = 1;
        c0 = bus.fetch_cnt_o;
        repeat (8) press();
        chk("step ignored delta", bus.fetch_cnt_o - c0, 32'd2);

        // PC and counter wrap
        run = 0;
        redir = 1; rpc = 32'hffff_ffff;
        cycle();
        idle();
        force dut.r_fetch_cnt = 32'hffff_ffff;
        #1 release dut.r_fetch_cnt;
        m_cnt = 32'hffff_ffff;
        press();
        chk("wrap pc",    bus.imem_addr_o,   32'h0);
        chk("wrap ipc",   bus.inst_pc_o,     32'hffff_ffff);
        chk("wrap cnt",   bus.fetch_cnt_o,   32'h0);
        chk("wrap4 pc",   bus_w.imem_addr_o, 4'h0);
        chk("wrap4 ipc",  bus_w.inst_pc_o,   4'hf);

        // randomized run against the model
        do_reset();
        run = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(63) == 0) run = ~run;
            if ($urandom_range(3) == 0) step = ~step;
            stall = ($urandom_range(3) == 0);
            redir = ($urandom_range(19) == 0);
            rpc   = $urandom;
            data  = $urandom;
            cycle();
            check_model($sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage that owns the PC and sits directly upstream of the register file and ALU.
- Drives the combinational instruction-memory address and captures the returned word into an instruction register for decode.
- Advances in two modes: free-running at a divided rate, or single-stepping from a push-button.
- Supports stall and PC redirect (branch/jump), and keeps a fetch counter for the seven-segment display.

Parameters:
PC_W, 32, PC / instruction-memory address width
RESET_PC, 0, PC value loaded on reset
PC_INC, 1, PC increment per fetch (1 = word-addressed IM)
DIV_W, 28, tick divider width; free-run tick period = 2^DIV_W clk cycles

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
run_i  input  1  1 = free-run on divider tick, 0 = single-step on step_i
step_i  input  1  raw step button, asynchronous to clk
stall_i  input  1  hold fetch; no advance while high
redirect_i  input  1  load redirect_pc_i into PC and flush instruction register
redirect_pc_i  input  PC_W  redirect target
imem_addr_o  output  PC_W  instruction-memory address, equal to the PC register
imem_data_i  input  32  combinational instruction-memory read data
inst_o  output  32  captured instruction
inst_pc_o  output  PC_W  PC of inst_o
inst_valid_o  output  1  inst_o holds a live instruction
fetch_cnt_o  output  32  count of completed fetches

Behaviour:
- Reset: asynchronous, active-high, on clk, rst only.
  - Reset values: pc=RESET_PC, inst_o=0, inst_pc_o=0, inst_valid_o=0, fetch_cnt_o=0.
  - Internal state cleared: divider=0, pending=0, step synchronizer/edge flops=0.
  - Reset asserted mid-operation aborts everything immediately; no event survives.
- imem_addr_o = pc, taken directly from the register; no combinational path from any input.
- Divider:
  - DIV_W-bit counter, increments every clk, wraps.
  - tick = 1 in the cycle the counter equals all-ones.
  - Counts in both modes.
- Step input path:
  - step_i passes through a 2-flop synchronizer, then a rising-edge detector.
  - step_rise is a one-cycle pulse on the 3rd clk edge after step_i rises.
  - A held button yields exactly one pulse.
- event = (run_i & tick) | (~run_i & step_rise).
- adv = (event | pending) & ~stall_i & ~redirect_i.
- Priority per cycle: redirect > stall > advance.
  - redirect_i=1: pc<=redirect_pc_i, inst_valid_o<=0, pending<=0. inst_o, inst_pc_o and fetch_cnt_o unchanged. A coincident event is discarded.
  - Else adv=1: inst_o<=imem_data_i, inst_pc_o<=pc, inst_valid_o<=1, pc<=pc+PC_INC (mod 2^PC_W), fetch_cnt_o<=fetch_cnt_o+1 (mod 2^32), pending<=0.
  - Else stall_i=1 with event: pending<=1. Pending is one-deep; further events while pending are merged. All registered outputs hold.
  - Else: all state holds.
- Latency:
  - An unstalled event captures on the same clk edge that ends the event cycle.
  - A pending event captures on the first edge with stall_i=0 and redirect_i=0.
- Mode changes:
  - run_i changing does not clear pending.
  - A tick while run_i=0 is ignored; a step while run_i=1 is ignored.
- PC wrap: pc = 2^PC_W - PC_INC advances to 0 with no flag.
- inst_valid_o stays 1 after the first fetch until a redirect clears it. It is not a one-cycle pulse.

Test Plan:
- Reset/hold (DIV_W=4, run_i=1): assert rst=1 mid-run -> all outputs return to reset values asynchronously. Release rst -> first capture on cycle 16, when the divider reaches 15. imem_addr_o=0 before and 1 after that capture. inst_pc_o=0, fetch_cnt_o=1.
- Single-step (run_i=0, imem_data_i=0x00500093): hold step_i high 20 cycles -> exactly one capture, 3 edges after the rise. inst_o=0x00500093, pc 0->1, fetch_cnt_o=1. A second press -> pc=2, fetch_cnt_o=2.
- Stall plus pending: stall_i=1, issue two step presses, then drop stall -> no change while stalled. Exactly one capture on the first edge after stall_i=0, so fetch_cnt_o increments by 1, not 2.
- Redirect priority: with pc=5, apply redirect_i=1, redirect_pc_i=0x40 in the same cycle as tick and with stall_i=1 -> pc=0x40, inst_valid_o=0, fetch_cnt_o unchanged. The next tick captures with inst_pc_o=0x40 and pc becomes 0x41.
- Wrap (PC_W=4, PC_INC=1): starting from pc=15, one advance -> pc=0 and inst_pc_o=15. Separately, with fetch_cnt_o forced to 0xFFFFFFFF, one advance -> fetch_cnt_o=0.
- Mode isolation: run_i=0 with ticks occurring -> no fetch. run_i=1 with step presses -> no extra fetches beyond one per tick.
